// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin arbiter family.
//   - arb_state_t : arbiter FSM state encoding (IDLE / GRANT / RELEASE)
//   - clog2()     : constant-evaluable ceiling log2, used for index widths
// No ports (package).
// ---------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    // Smallest r such that (1 << r) >= value; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_fsm_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_fsm_arbiter_if
// Request/grant bundle between N requesters and the round-robin arbiter.
//   req     [N]   : per-requester request level
//   gnt     [N]   : registered one-hot grant
//   gnt_id  [IDW] : binary index of current/last owner
//   busy          : any grant active
//   preempt       : one-cycle pulse when a tenure is cut by the hold limit
//   lock          : (only with ARB_LOCK_EN) suppress the hold limit
// Modports: master = arbiter side, slave = requester side.
// Optional feature macro: ARB_LOCK_EN
// ---------------------------------------------------------------------------
interface rr_fsm_arbiter_if #(
    parameter int N = 4
);
    import arb_pkg::*;

    localparam int IDW = clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           preempt;
`ifdef ARB_LOCK_EN
    logic           lock;

    modport master (input req, input lock,
                    output gnt, output gnt_id, output busy, output preempt);
    modport slave  (output req, output lock,
                    input gnt, input gnt_id, input busy, input preempt);
`else
    modport master (input req,
                    output gnt, output gnt_id, output busy, output preempt);
    modport slave  (output req,
                    input gnt, input gnt_id, input busy, input preempt);
`endif

endinterface

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner search. Scans req starting at last+1
// and wrapping at N-1 -> 0; the nearest set bit after last wins.
//   req        [N]   in  : request vector
//   last       [IDW] in  : index of previous owner (lowest priority)
//   any              out : at least one request present
//   win_id     [IDW] out : winning index (0 when any==0)
//   win_onehot [N]   out : winning index as one-hot (0 when any==0)
// ---------------------------------------------------------------------------
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IDW = clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic           any,
    output logic [IDW-1:0] win_id,
    output logic [N-1:0]   win_onehot
);

    logic [2*N-1:0] w_dbl;
    logic [IDW:0]   w_shamt;
    logic [N-1:0]   w_rot;

    // Rotate so that bit p of w_rot is req[(last+1+p) mod N]; the lowest
    // set bit of w_rot is then the round-robin winner's distance from last.
    assign w_dbl   = {req, req};
    assign w_shamt = {1'b0, last} + (IDW+1)'(1);
    assign w_rot   = N'(w_dbl >> w_shamt);

    always_comb begin
        int w_off;
        int w_sum;
        any    = 1'b0;
        w_off  = 0;
        w_sum  = 0;
        win_id = '0;
        // Descending scan so the smallest offset is the last one written.
        for (int p = N - 1; p >= 0; p--) begin
            if (w_rot[p]) begin
                any   = 1'b1;
                w_off = p;
            end
        end
        if (any) begin
            w_sum = int'(last) + 1 + w_off;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            win_id = IDW'(w_sum);
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign win_onehot[gi] = any && (win_id == IDW'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_fsm_arbiter.sv
// ---------------------------------------------------------------------------
// rr_fsm_arbiter
// Round-robin arbiter that hands a single-owner datapath to one of N
// requesters at a time. Grant is registered (1-clock req->gnt latency),
// each tenure is bounded to MAX_HOLD cycles, and exactly one dead cycle
// (RELEASE) separates consecutive owners.
// Ports:
//   clk    in  : rising-edge clock
//   reset  in  : asynchronous active-low reset
//   bus    rr_fsm_arbiter_if.master : req/lock in, gnt/gnt_id/busy/preempt out
// Parameters: N (2..16) requesters, MAX_HOLD (>=1) cycles per tenure.
// Optional feature macro: ARB_LOCK_EN (lock input suppresses the hold limit).
// ---------------------------------------------------------------------------
module rr_fsm_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    rr_fsm_arbiter_if.master bus
);

    localparam int IDW = clog2(N);
    localparam int HW  = clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] LAST_INIT = IDW'(N - 1);

    arb_state_t     r_state,    w_state_next;
    logic [N-1:0]   r_gnt,      w_gnt_next;
    logic [IDW-1:0] r_gnt_id,   w_gnt_id_next;
    logic [IDW-1:0] r_last,     w_last_next;
    logic           r_busy,     w_busy_next;
    logic           r_preempt,  w_preempt_next;
    logic [HW-1:0]  r_hold_cnt, w_hold_cnt_next;

    logic           w_any;
    logic [IDW-1:0] w_win_id;
    logic [N-1:0]   w_win_onehot;
    logic           w_own_req;
    logic           w_lock;
    logic           w_at_limit;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req        (bus.req),
        .last       (r_last),
        .any        (w_any),
        .win_id     (w_win_id),
        .win_onehot (w_win_onehot)
    );

`ifdef ARB_LOCK_EN
    assign w_lock = bus.lock;
`else
    assign w_lock = 1'b0;
`endif

    // Only the current owner's request line matters during a tenure.
    assign w_own_req  = bus.req[r_gnt_id];
    assign w_at_limit = (r_hold_cnt == HOLD_LAST) && !w_lock;

    always_comb begin
        w_state_next    = r_state;
        w_gnt_next      = r_gnt;
        w_gnt_id_next   = r_gnt_id;
        w_last_next     = r_last;
        w_busy_next     = r_busy;
        w_preempt_next  = 1'b0;
        w_hold_cnt_next = r_hold_cnt;

        case (r_state)
            ST_IDLE, ST_RELEASE: begin
                w_hold_cnt_next = '0;
                if (w_any) begin
                    w_state_next  = ST_GRANT;
                    w_gnt_next    = w_win_onehot;
                    w_gnt_id_next = w_win_id;
                    w_busy_next   = 1'b1;
                end else begin
                    w_state_next  = ST_IDLE;
                    w_gnt_next    = '0;
                    w_busy_next   = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!w_own_req || w_at_limit) begin
                    w_state_next    = ST_RELEASE;
                    w_gnt_next      = '0;
                    w_busy_next     = 1'b0;
                    w_last_next     = r_gnt_id;
                    w_hold_cnt_next = '0;
                    // A voluntary drop coinciding with the limit is not a preemption.
                    w_preempt_next  = w_own_req && w_at_limit;
                end else if (r_hold_cnt != HOLD_LAST) begin
                    // Saturates at HOLD_LAST, which only persists while locked.
                    w_hold_cnt_next = r_hold_cnt + HW'(1);
                end
            end
            default: begin
                w_state_next    = ST_IDLE;
                w_gnt_next      = '0;
                w_busy_next     = 1'b0;
                w_hold_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_last     <= LAST_INIT;
            r_busy     <= 1'b0;
            r_preempt  <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_gnt      <= w_gnt_next;
            r_gnt_id   <= w_gnt_id_next;
            r_last     <= w_last_next;
            r_busy     <= w_busy_next;
            r_preempt  <= w_preempt_next;
            r_hold_cnt <= w_hold_cnt_next;
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.gnt_id  = r_gnt_id;
    assign bus.busy    = r_busy;
    assign bus.preempt = r_preempt;

endmodule

// File: doc/rr_fsm_arbiter.md
Name: rr_fsm_arbiter

Overview:
- Round-robin arbiter that shares one single-owner FSM datapath between N requesters.
- Issues a registered one-hot grant, bounds each tenure to MAX_HOLD cycles, and forces one dead cycle between owners for bus turnaround.
- Sits in front of the shared FSM: the granted requester's inputs are muxed onto the FSM's a/b using gnt_id.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive grant cycles per tenure (>=1).
- IDW, $clog2(N), width of gnt_id (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  N  per-requester request level; held high while the requester wants or uses the resource.
- gnt  output  N  registered one-hot grant, all-zero when idle.
- gnt_id  output  IDW  binary index of current/last owner.
- busy  output  1  high while any gnt bit is high.
- preempt  output  1  one-cycle pulse when a tenure is ended by the MAX_HOLD limit.

Behaviour:
- Reset (reset=0, async): state=IDLE, gnt=0, gnt_id=0, busy=0, preempt=0, hold_cnt=0, last=N-1, so req[0] wins first.
- States: IDLE, GRANT, RELEASE (2-bit encoding).
- IDLE:
  - Arbitration is combinational on req, searching from index last+1 upward with wrap at N-1 -> 0.
  - If any req bit is set, the next edge loads gnt/gnt_id with the winner, sets busy=1, hold_cnt=0, and moves to GRANT.
  - Latency req->gnt is 1 clock.
- GRANT:
  - hold_cnt increments every cycle.
  - Leave GRANT when req[gnt_id]==0 (voluntary) or hold_cnt==MAX_HOLD-1 (limit).
  - On exit: gnt=0, busy=0, last=gnt_id, gnt_id keeps its value, state=RELEASE.
  - preempt=1 for that one cycle only if the exit was due to the limit and req[gnt_id] was still high.
  - A tenure lasts at most MAX_HOLD cycles. With MAX_HOLD=1, every tenure is exactly 1 cycle.
- RELEASE:
  - gnt=0 for exactly one cycle.
  - Arbitration as in IDLE: any req -> GRANT on the next edge, otherwise -> IDLE. The gap between owners is therefore exactly 1 cycle.
  - A preempted requester that keeps req high competes again but has lowest priority.
- Simultaneous requests: the nearest index after last wins. Requests arriving during GRANT wait and are not latched; a request dropped before arbitration is lost.
- Only one gnt bit is ever high. gnt is never high in IDLE or RELEASE.
- Reset asserted mid-GRANT clears gnt immediately (asynchronously). After reset, priority restarts at req[0].
- req bits for indices the arbiter does not grant are ignored in GRANT.

Optional Feature:
- ARB_LOCK_EN defined:
  - Adds input port lock (1 bit).
  - In GRANT, while lock==1, the MAX_HOLD limit is suppressed: hold_cnt saturates at MAX_HOLD-1 and there is no preempt. Voluntary release still applies.
  - lock is ignored outside GRANT.
- Not defined: no lock port, limit always enforced.

Decomposition:
- Shared package/include arb_pkg:
  - state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_RELEASE=2'd2.
  - function clog2 for IDW.
- Sub-module rr_pick (combinational):
  - inputs req[N], last[IDW]; outputs any, win_id[IDW], win_onehot[N].
  - Reused by future arbiters.
- Top holds the state register, hold_cnt (width $clog2(MAX_HOLD)+1), last, and the output registers.

Test Plan (N=4, MAX_HOLD=8, 20 ns clock):
- Reset with req=4'b1111, then reset=1 -> gnt=0001 one edge later, gnt_id=0, busy=1; reset=0 mid-grant clears gnt=0000 immediately (asynchronously).
- req=4'b0100 held for 3 cycles, then dropped -> gnt=0100 for 3 cycles, 1 RELEASE cycle, IDLE, preempt stays 0.
- req=4'b1111 held continuously -> grants 0001,0010,0100,1000,0001…; each tenure is 8 cycles with gnt=0 for 1 cycle between; preempt pulses once per tenure.
- After owner 2 (last=2), set req=4'b0101 -> next grant goes to index 0 (wrap past 3), not 2.
- MAX_HOLD=1 build, req=4'b0011 -> alternating gnt 0001,0000,0010,0000…; preempt=1 on each release.
- ARB_LOCK_EN, req=4'b0011, lock=1 for 20 cycles -> gnt=0001 for 20 cycles with no preempt; after lock=0 the next edge ends the tenure with a preempt pulse, then gnt=0010 after the 1-cycle gap.
